// File: rtl/sccb_commit_sequencer.sv
// SCCB commit sequencer: walks the register buffer in index order and issues one
// SCCB write per {reg_addr, reg_data} word until a terminator word, the last
// entry, a slave NACK, an ack timeout, or an abort.
module sccb_commit_sequencer #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned IDX_W     = 6,
  parameter logic [15:0] TERM_WORD = 16'hFFFF,
  parameter int unsigned TIMEOUT   = 4095,
  parameter int unsigned TO_W      = 12
) (
  input  logic             clk_fast,
  input  logic             g_nrst,
  input  logic             start,
  input  logic             abort,
  output logic             buff_port_rd,
  output logic [IDX_W-1:0] buff_port_indx,
  input  logic [15:0]      buff_port_dout,
  output logic             sccb_req,
  output logic [7:0]       sccb_addr,
  output logic [7:0]       sccb_data,
  input  logic             sccb_ack,
  input  logic             sccb_err,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W:0]   wr_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StLatch = 3'd2,
    StCheck = 3'd3,
    StReq   = 3'd4,
    StNext  = 3'd5,
    StDone  = 3'd6,
    StErr   = 3'd7
  } state_e;

  state_e          state_q;
  logic [15:0]     word_q;
  logic [TO_W-1:0] timeout_q;

  assign dbg_state = state_q;

  // Sequencer FSM; every output is registered and updated on the edge entering a state.
  always_ff @(posedge clk_fast or negedge g_nrst) begin
    if (!g_nrst) begin
      state_q        <= StIdle;
      word_q         <= '0;
      timeout_q      <= '0;
      buff_port_rd   <= 1'b0;
      buff_port_indx <= '0;
      sccb_req       <= 1'b0;
      sccb_addr      <= '0;
      sccb_data      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      wr_count       <= '0;
    end else if (abort && (state_q != StIdle)) begin
      // Abort beats any same-cycle ack: index, count and err all hold.
      state_q      <= StIdle;
      buff_port_rd <= 1'b0;
      sccb_req     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_q        <= StRd;
            buff_port_indx <= '0;
            buff_port_rd   <= 1'b1;
            wr_count       <= '0;
            err            <= 1'b0;
            busy           <= 1'b1;
          end
        end
        StRd: begin
          buff_port_rd <= 1'b0;
          state_q      <= StLatch;
        end
        StLatch: begin
          word_q  <= buff_port_dout;
          state_q <= StCheck;
        end
        StCheck: begin
          if (word_q == TERM_WORD) begin
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            sccb_addr <= word_q[15:8];
            sccb_data <= word_q[7:0];
            timeout_q <= '0;
            sccb_req  <= 1'b1;
            state_q   <= StReq;
          end
        end
        StReq: begin
          timeout_q <= timeout_q + 1'b1;
          if (sccb_ack) begin
            sccb_req <= 1'b0;
            if (sccb_err) begin
              state_q <= StErr;
              err     <= 1'b1;
              busy    <= 1'b0;
            end else begin
              wr_count <= wr_count + 1'b1;
              state_q  <= StNext;
            end
          end else if (timeout_q == TO_W'(TIMEOUT)) begin
            sccb_req <= 1'b0;
            state_q  <= StErr;
            err      <= 1'b1;
            busy     <= 1'b0;
          end
        end
        StNext: begin
          // The last entry ends the walk; the index never wraps.
          if (buff_port_indx == IDX_W'(DEPTH - 1)) begin
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            buff_port_indx <= buff_port_indx + 1'b1;
            buff_port_rd   <= 1'b1;
            state_q        <= StRd;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
